// File: rtl/expr_sched_pkg.sv
// Shared types, constants and pure helpers for the expression vector scheduler.
package expr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] SIG_INIT  = 32'hFFFFFFFF;
  localparam int          OP_W      = 60;
  localparam int          RES_W     = 90;

  // Right-shift Galois step; the mask is applied when the bit shifted out is set.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] misr_fold(input logic [31:0] s, input logic [RES_W-1:0] res);
    logic [31:0] r;
    r = res[31:0] ^ res[63:32] ^ {6'b00_0000, res[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0000_0000) ^ r;
  endfunction

endpackage

// File: rtl/expr_misr32.sv
// 32-bit MISR: folds the 90-bit datapath result into a running signature.
module expr_misr32
  import expr_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             en,
  input  logic [RES_W-1:0] res,
  output logic [31:0]      sig,
  output logic [31:0]      sig_next
);

  // Next signature: init wins over a fold, otherwise hold.
  always_comb begin
    sig_next = sig;
    if (init) begin
      sig_next = SIG_INIT;
    end else if (en) begin
      sig_next = misr_fold(sig, res);
    end else begin
      sig_next = sig;
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= 32'h0000_0000;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/expr_vec_sched.sv
// LFSR-driven stimulus scheduler: applies operand vectors, waits SETTLE cycles,
// folds each result into a MISR and compares the final signature.
module expr_vec_sched
  import expr_sched_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [31:0]      exp_sig,
  output logic [OP_W-1:0]  op,
  output logic             op_valid,
  input  logic [RES_W-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      sig,
  output logic [CNT_W-1:0] vec_cnt
);

  state_t           state_r, next_s;
  logic [31:0]      lfsr_r, base_s, s1_s, s2_s, sig_next_s, exp_r, exp_next_s;
  logic [CNT_W-1:0] num_r, cnt_inc_s;
  logic [15:0]      wait_r;
  logic             launch_s, capture_s, last_s;

  assign launch_s   = (state_r == IDLE) && start && !abort;
  assign capture_s  = (state_r == CAPTURE) && !abort;
  assign cnt_inc_s  = vec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_s     = (cnt_inc_s == num_r);
  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign base_s     = launch_s ? ((seed == 32'h0000_0000) ? 32'h0000_0001 : seed) : lfsr_r;
  assign s1_s       = lfsr_step(base_s);
  assign s2_s       = lfsr_step(s1_s);
  assign exp_next_s = launch_s ? exp_sig : exp_r;

  expr_misr32 u_misr (
    .clk      (clk),
    .reset    (reset),
    .init     (launch_s),
    .en       (capture_s),
    .res      (res),
    .sig      (sig),
    .sig_next (sig_next_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; abort overrides every active state.
  always_comb begin
    next_s = state_r;
    if ((state_r != IDLE) && abort) begin
      next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            next_s = (num_vec == {CNT_W{1'b0}}) ? DONE : APPLY;
          end else begin
            next_s = IDLE;
          end
        end
        APPLY: begin
          if (SETTLE > 0) begin
            next_s = WAIT;
          end else begin
            next_s = CAPTURE;
          end
        end
        WAIT: begin
          if (wait_r == 16'h0000) begin
            next_s = CAPTURE;
          end else begin
            next_s = WAIT;
          end
        end
        CAPTURE: next_s = last_s ? DONE : APPLY;
        DONE:    next_s = IDLE;
        default: next_s = IDLE;
      endcase
    end
  end

  // Datapath registers and outputs, all decoded from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r   <= 32'h0000_0001;
      num_r    <= {CNT_W{1'b0}};
      exp_r    <= 32'h0000_0000;
      wait_r   <= 16'h0000;
      op       <= {OP_W{1'b0}};
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      vec_cnt  <= {CNT_W{1'b0}};
    end else begin
      busy     <= (next_s != IDLE);
      op_valid <= (next_s == APPLY) || (next_s == WAIT) || (next_s == CAPTURE);
      done     <= (next_s == DONE);
      if (launch_s) begin
        num_r   <= num_vec;
        exp_r   <= exp_sig;
        vec_cnt <= {CNT_W{1'b0}};
        lfsr_r  <= base_s;
      end
      if (next_s == APPLY) begin
        op     <= {s1_s[29:0], s2_s[29:0]};
        lfsr_r <= s2_s;
      end
      if (capture_s) begin
        vec_cnt <= cnt_inc_s;
      end
      // pass tracks the signature that is final on entry to DONE.
      if (next_s == DONE) begin
        pass <= (sig_next_s == exp_next_s);
      end else if (launch_s) begin
        pass <= 1'b0;
      end
      if (state_r == APPLY) begin
        wait_r <= 16'(SETTLE - 1);
      end else if (state_r == WAIT) begin
        wait_r <= wait_r - 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_expr_vec_sched.sv
// Directed self-checking bench for expr_vec_sched with an independent LFSR/MISR model.
module tb_expr_vec_sched;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] seed, exp_sig, sig;
  logic [15:0] num_vec, vec_cnt;
  logic [59:0] op, op_exp;
  logic [89:0] res;
  logic        op_valid, busy, done, pass;
  logic        res_zero, flip_on;
  logic [31:0] m;
  int          checks = 0;
  int          errors = 0;
  int          dcount;

  expr_vec_sched #(.SETTLE(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .num_vec(num_vec), .exp_sig(exp_sig), .op(op), .op_valid(op_valid),
    .res(res), .busy(busy), .done(done), .pass(pass), .sig(sig), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_step(logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h80200003;
    return y;
  endfunction

  function automatic logic [31:0] m_fold(logic [31:0] s, logic [89:0] y);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ 32'h04C11DB7;
    return n ^ y[31:0] ^ y[63:32] ^ {6'd0, y[89:64]};
  endfunction

  // Stand-in expression datapath: product of the two operand halves plus a rotate-xor.
  function automatic logic [89:0] m_expr(logic [59:0] o);
    logic [59:0] p;
    p = {30'd0, o[59:30]} * {30'd0, o[29:0]};
    return {p, o[59:30] ^ {o[14:0], o[29:15]}};
  endfunction

  function automatic logic [31:0] model_sig(logic [31:0] sd, int n, logic zero, int flip);
    logic [31:0] l, s1, s2, s;
    logic [89:0] y;
    l = (sd == 32'd0) ? 32'd1 : sd;
    s = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      s1 = m_step(l);
      s2 = m_step(s1);
      l  = s2;
      y  = zero ? 90'd0 : m_expr({s1[29:0], s2[29:0]});
      if (i == flip) y[0] = ~y[0];
      s = m_fold(s, y);
    end
    return s;
  endfunction

  always_comb res = res_zero ? 90'd0
                  : (m_expr(op) ^ ((flip_on && vec_cnt == 16'd499) ? 90'd1 : 90'd0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start is sampled on the next edge (cycle 0); returns in cycle 1.
  task automatic launch(logic [31:0] sd, logic [15:0] n, logic [31:0] e);
    seed = sd; num_vec = n; exp_sig = e; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int cyc0, int expect_cyc);
    int cyc;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk(tag, cyc, expect_cyc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; abort = 1'b0; seed = 32'd0; num_vec = 16'd0;
    exp_sig = 32'd0; res_zero = 1'b0; flip_on = 1'b0;
    op_exp = {30'h00200003, 30'h00300002};
    repeat (3) tick();
    chk("rst_op", op, 60'd0);
    chk("rst_sig", sig, 32'd0);
    chk("rst_vec_cnt", vec_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_op_valid", op_valid, 1'b0);
    start = 1'b0; reset = 1'b0;
    tick();

    // Zero vectors: straight to DONE.
    launch(32'h1234, 16'd0, 32'hFFFFFFFF);
    chk("nv0_done", done, 1'b1);
    chk("nv0_sig", sig, 32'hFFFFFFFF);
    chk("nv0_pass", pass, 1'b1);
    chk("nv0_op_valid", op_valid, 1'b0);
    tick();
    chk("nv0_done_pulse", done, 1'b0);
    chk("nv0_busy", busy, 1'b0);
    chk("nv0_pass_hold", pass, 1'b1);

    // Seed 0 and seed 1 produce the same first vector.
    m = model_sig(32'd0, 1, 1'b0, -1);
    launch(32'd0, 16'd1, 32'd0);
    chk("seed0_op", op, op_exp);
    chk("seed0_op_valid", op_valid, 1'b1);
    wait_done("seed0_done_cycle", 1, 5);
    chk("seed0_sig", sig, m);
    chk("seed0_pass", pass, (m == 32'd0));
    tick();
    launch(32'd1, 16'd1, m);
    chk("seed1_op", op, op_exp);
    wait_done("seed1_done_cycle", 1, 5);
    chk("seed1_pass", pass, 1'b1);
    chk("seed1_vec_cnt", vec_cnt, 16'd1);
    tick();

    // Three zero results; a start while busy must be ignored.
    res_zero = 1'b1;
    m = model_sig(32'h12345678, 3, 1'b1, -1);
    launch(32'h12345678, 16'd3, m);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("zero3_done_cycle", 2, 13);
    chk("zero3_vec_cnt", vec_cnt, 16'd3);
    chk("zero3_sig", sig, m);
    chk("zero3_pass", pass, 1'b1);
    tick();
    res_zero = 1'b0;

    // Abort in the WAIT of vector 2 (cycle 6).
    launch(32'hCAFEF00D, 16'd5, 32'd0);
    repeat (5) tick();
    chk("abort_pre_valid", op_valid, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_op_valid", op_valid, 1'b0);
    chk("abort_vec_cnt", vec_cnt, 16'd1);
    chk("abort_sig", sig, model_sig(32'hCAFEF00D, 1, 1'b0, -1));
    chk("abort_pass", pass, 1'b0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("abort_no_done", dcount, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    m = model_sig(32'hCAFEF00D, 2, 1'b0, -1);
    launch(32'hCAFEF00D, 16'd2, m);
    chk("rerun_sig_init", sig, 32'hFFFFFFFF);
    chk("rerun_vec_cnt", vec_cnt, 16'd0);
    wait_done("rerun_done_cycle", 1, 9);
    chk("rerun_pass", pass, 1'b1);
    chk("rerun_vec_cnt_end", vec_cnt, 16'd2);
    tick();

    // Asynchronous reset mid-CAPTURE with start held.
    launch(32'd5, 16'd3, 32'd0);
    repeat (3) tick();
    chk("rst_mid_valid", op_valid, 1'b1);
    #2;
    reset = 1'b1; start = 1'b1;
    #1;
    chk("arst_op", op, 60'd0);
    chk("arst_sig", sig, 32'd0);
    chk("arst_vec_cnt", vec_cnt, 16'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_op_valid", op_valid, 1'b0);
    tick();
    tick();
    chk("arst_start_ignored", busy, 1'b0);
    reset = 1'b0;
    tick();
    chk("arst_start_after", busy, 1'b1);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("arst_cleanup", busy, 1'b0);

    // Long run against the golden signature, then with one corrupted result.
    m = model_sig(32'h0BADBEEF, 1000, 1'b0, -1);
    launch(32'h0BADBEEF, 16'd1000, m);
    wait_done("long_done_cycle", 1, 4001);
    chk("long_pass", pass, 1'b1);
    chk("long_vec_cnt", vec_cnt, 16'd1000);
    tick();
    flip_on = 1'b1;
    launch(32'h0BADBEEF, 16'd1000, m);
    wait_done("flip_done_cycle", 1, 4001);
    chk("flip_pass", pass, 1'b0);
    chk("flip_sig", sig, model_sig(32'h0BADBEEF, 1000, 1'b0, 499));
    tick();
    flip_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_vec_sched.md
Name: expr_vec_sched

Overview:
- Clocked stimulus scheduler for the flat combinational expression datapaths in the vloghammer regression set (12 operands a0..a5/b0..b5, 90-bit result y).
- Generates pseudo-random operand vectors from an LFSR and applies each one to the datapath. It waits a programmable settle time, captures y, and folds it into a 32-bit MISR signature.
- Compares the final signature with an expected value so that equivalence runs can be done in hardware or simulation.

Parameters:
- SETTLE, 2, cycles operands are held after APPLY before y is sampled (0 allowed)
- CNT_W, 16, width of vector count

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch a run; sampled only in IDLE
- abort  in  1  cancel the active run
- seed  in  32  LFSR seed, latched on start
- num_vec  in  CNT_W  number of vectors to apply, latched on start
- exp_sig  in  32  expected signature, latched on start
- op  out  60  operands: {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, MSB first (widths 4,5,6,4,5,6 twice)
- op_valid  out  1  high in APPLY/WAIT/CAPTURE
- res  in  90  datapath result y
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse in DONE
- pass  out  1  sig==exp_sig, valid from DONE until next start
- sig  out  32  running/final signature
- vec_cnt  out  CNT_W  vectors captured so far in the current run

Behaviour:
- Reset values: all outputs 0 (op, sig, vec_cnt, pass included); state=IDLE; LFSR=32'h1.
- LFSR: 32-bit right-shift Galois, mask 32'h80200003. step(x) = (x>>1) ^ (x[0] ? mask : 0). A seed of 0 is replaced by 32'h1.
- Operand generation on entry to APPLY: s1=step(lfsr), s2=step(s1). Then op <= {s1[29:0], s2[29:0]} and lfsr <= s2. op holds constant through WAIT and CAPTURE.
- MISR update in CAPTURE:
  - r = res[31:0] ^ res[63:32] ^ {6'b0, res[89:64]}
  - sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ r
- States:
  - IDLE: on start (and not abort), latch seed/num_vec/exp_sig, set sig=32'hFFFFFFFF and vec_cnt=0, clear pass. Go to DONE if num_vec==0, otherwise to APPLY (generating the first op).
  - APPLY: 1 cycle. Go to WAIT if SETTLE>0, else to CAPTURE.
  - WAIT: exactly SETTLE cycles (down-counter), then CAPTURE.
  - CAPTURE: sample res, update sig, vec_cnt++. If vec_cnt+1==num_vec go to DONE; else go to APPLY (generating the next op).
  - DONE: done=1 and pass=(sig==exp_sig). Go to IDLE next cycle.
- Timing: each vector takes SETTLE+2 cycles. If start is sampled at cycle 0, done is high at cycle 1+num_vec*(SETTLE+2).
- abort in any non-IDLE state: next state is IDLE, op_valid drops and no done pulse is issued. sig and vec_cnt hold their partial values; pass stays 0.
- Simultaneous start and abort in IDLE: abort wins and the run does not start.
- start while busy is ignored.
- Asynchronous reset mid-run returns immediately to the reset values above.
- vec_cnt saturates by construction, since it never exceeds num_vec. num_vec = 2^CNT_W-1 is legal.

Decomposition:
- Package expr_sched_pkg holds:
  - the state enum {IDLE, APPLY, WAIT, CAPTURE, DONE}
  - constants LFSR_MASK=32'h80200003, MISR_POLY=32'h04C11DB7, SIG_INIT=32'hFFFFFFFF, OP_W=60, RES_W=90
  - pure functions lfsr_step and misr_fold
- One sub-module is natural: expr_misr32 (fold + shift register, with init and enable). LFSR and FSM stay in the top module.

Test Plan:
- num_vec=0, start at cycle 0 -> done at cycle 1, sig=32'hFFFFFFFF, pass=1 when exp_sig=32'hFFFFFFFF, op_valid never high.
- seed=0 vs seed=1, num_vec=1, SETTLE=2 -> identical op in both runs. From lfsr=1: s1=32'h80200003, s2=32'hC0300002, so op={30'h00200003, 30'h00300002}. done at cycle 5.
- num_vec=3, SETTLE=2, res tied to 0 -> done at cycle 13, vec_cnt=3. sig = MISR of three zero folds from FFFFFFFF, computed by the model.
- abort asserted in the WAIT of vector 2 (num_vec=5) -> IDLE next cycle, no done, vec_cnt=1, busy=0. A following start runs cleanly from SIG_INIT.
- Reset asserted mid-CAPTURE -> all outputs 0 in the same cycle (async). start is held during reset and is ignored until reset deasserts.
- Connect an expression datapath, run num_vec=1000 with exp_sig from the golden model -> pass=1. Then flip one res bit on vector 500 -> pass=0.
